// File: rtl/regfile_dump_reader.sv
// Register file dump engine: walks x0/x1..x31 through a read port and
// streams (index, value) beats on a valid/ready channel, then pulses done.
module regfile_dump_reader #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  regAddress,
    input  logic [31:0] regValue,
    output logic        outValid,
    input  logic        outReady,
    output logic [4:0]  outIndex,
    output logic [31:0] outData,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_e;

    localparam logic [4:0] FIRST_REG = SKIP_ZERO ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST_REG  = 5'd31;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = FIRST_REG;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Beat is snapshotted here; later writebacks are not seen.
                data_d  = regValue;
                index_d = cnt_q;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (valid_q && outReady) begin
                    valid_d = 1'b0;
                    if (cnt_q == LAST_REG) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = 5'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            cnt_d   = 5'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            valid_q <= 1'b0;
            index_q <= 5'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    assign regAddress = (state_q == S_FETCH) ? cnt_q : 5'd0;
    assign outValid   = valid_q;
    assign outIndex   = index_q;
    assign outData    = data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: instance 0 has SKIP_ZERO=0,
// instance 1 has SKIP_ZERO=1; both read a shared register file model.
module tb_regfile_dump_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] rf [32];
    logic        rst_n [2];
    logic        start [2];
    logic        abort [2];
    logic        rdy   [2];
    logic        valid [2];
    logic        busy  [2];
    logic        done  [2];
    logic [4:0]  addr  [2];
    logic [4:0]  idx   [2];
    logic [31:0] rv    [2];
    logic [31:0] data  [2];
    int          stall_lo [2];
    int          stall_hi [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign rdy[g] = !(cyc >= stall_lo[g] && cyc < stall_hi[g]);
        assign rv[g]  = (addr[g] == 5'd0) ? 32'd0 : rf[addr[g]];
        regfile_dump_reader #(.SKIP_ZERO(g == 1)) u_dut (
            .clock      (clock),
            .reset      (rst_n[g]),
            .start      (start[g]),
            .abort      (abort[g]),
            .regAddress (addr[g]),
            .regValue   (rv[g]),
            .outValid   (valid[g]),
            .outReady   (rdy[g]),
            .outIndex   (idx[g]),
            .outData    (data[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

    typedef struct packed {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        int   i;
        int   cyc;
        logic busy;
        logic chk_valid;
        logic valid;
        logic zero_all;
    } snap_t;

    beat_t beat_q [2][$];
    int    done_q [2][$];
    snap_t snap_q [$];

    int checks = 0;
    int errors = 0;
    bit timed_out = 1'b0;
    bit final_req = 1'b0;
    bit final_done = 1'b0;

    // Monitor: compares DUT outputs against whatever stimulus queued.
    always @(negedge clock) begin
        beat_t e;
        snap_t sn;
        int    dc;
        bit    bad;
        for (int i = 0; i < 2; i++) begin
            if (valid[i] && rdy[i]) begin
                checks++;
                if (beat_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL beat dut%0d: unexpected idx=%0d data=%h cycle=%0d",
                             i, idx[i], data[i], cyc);
                end else begin
                    e = beat_q[i].pop_front();
                    if (idx[i] !== e.idx || data[i] !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL beat dut%0d: got idx=%0d data=%h cycle=%0d, expected idx=%0d data=%h cycle=%0d",
                                 i, idx[i], data[i], cyc, e.idx, e.data, e.cyc);
                    end
                end
            end else if (valid[i] && beat_q[i].size() > 0) begin
                checks++;
                e = beat_q[i][0];
                if (idx[i] !== e.idx || data[i] !== e.data) begin
                    errors++;
                    $display("FAIL hold dut%0d cycle=%0d: got idx=%0d data=%h, expected idx=%0d data=%h",
                             i, cyc, idx[i], data[i], e.idx, e.data);
                end
            end
            if (done[i] === 1'b1) begin
                checks++;
                if (done_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL done dut%0d: unexpected pulse at cycle=%0d", i, cyc);
                end else begin
                    dc = done_q[i].pop_front();
                    if (dc != cyc) begin
                        errors++;
                        $display("FAIL done dut%0d: pulse at cycle=%0d, expected cycle=%0d",
                                 i, cyc, dc);
                    end
                end
            end
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            sn = snap_q.pop_front();
            checks++;
            bad = (sn.cyc != cyc) || (busy[sn.i] !== sn.busy);
            if (sn.chk_valid && valid[sn.i] !== sn.valid) bad = 1'b1;
            if (sn.zero_all && (addr[sn.i] !== 5'd0 || valid[sn.i] !== 1'b0 ||
                idx[sn.i] !== 5'd0 || data[sn.i] !== 32'd0 || done[sn.i] !== 1'b0))
                bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL snap dut%0d cycle=%0d: busy=%b valid=%b addr=%0d idx=%0d data=%h done=%b, expected cycle=%0d busy=%b valid=%b zero=%b",
                         sn.i, cyc, busy[sn.i], valid[sn.i], addr[sn.i], idx[sn.i],
                         data[sn.i], done[sn.i], sn.cyc, sn.busy, sn.valid, sn.zero_all);
            end
        end
        if (final_req && !final_done) begin
            final_done = 1'b1;
            checks++;
            if (timed_out || beat_q[0].size() != 0 || beat_q[1].size() != 0 ||
                done_q[0].size() != 0 || done_q[1].size() != 0 || snap_q.size() != 0) begin
                errors++;
                $display("FAIL drain: timed_out=%b pending beats=%0d/%0d dones=%0d/%0d snaps=%0d, expected all 0",
                         timed_out, beat_q[0].size(), beat_q[1].size(),
                         done_q[0].size(), done_q[1].size(), snap_q.size());
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic launch(input int i, output int s);
        @(negedge clock);
        s = cyc;
        start[i] = 1'b1;
        @(negedge clock);
        start[i] = 1'b0;
    endtask

    task automatic push_snap(input int i, input int c, input bit b,
                             input bit cv, input bit v, input bit z);
        snap_t sn;
        sn.i = i;
        sn.cyc = c;
        sn.busy = b;
        sn.chk_valid = cv;
        sn.valid = v;
        sn.zero_all = z;
        snap_q.push_back(sn);
    endtask

    // Expected beats for a dump started at cycle s; bb = x5 overwritten.
    task automatic plan(input int i, input int s, input int nb, input int stall_beat,
                        input int stall_n, input bit with_done, input bit bb);
        int    total;
        int    r;
        beat_t b;
        total = 32 - i;
        for (int k = 0; k < nb; k++) begin
            r = k + i;
            b.idx = 5'(r);
            if (r == 0) b.data = 32'd0;
            else if (bb && r == 5) b.data = 32'hDEADBEEF;
            else b.data = 32'hA500_0000 + 32'(r);
            b.cyc = s + 2 + 2 * k + ((k >= stall_beat) ? stall_n : 0);
            beat_q[i].push_back(b);
        end
        if (with_done) done_q[i].push_back(s + 2 + 2 * (total - 1) + 1 + stall_n);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((beat_q[0].size() + beat_q[1].size() + done_q[0].size() +
                done_q[1].size() + snap_q.size()) != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (n >= limit) timed_out = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int s;
        for (int r = 0; r < 32; r++) rf[r] = 32'hA500_0000 + 32'(r);
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            start[i] = 1'b0;
            abort[i] = 1'b0;
            stall_lo[i] = 0;
            stall_hi[i] = 0;
        end
        @(negedge clock);
        @(negedge clock);
        push_snap(0, cyc + 1, 1'b0, 1'b1, 1'b0, 1'b1);
        push_snap(1, cyc + 1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Full dump, no backpressure; busy high through cycle 65 only.
        launch(0, s);
        plan(0, s, 32, 32, 0, 1'b1, 1'b0);
        for (int c = 2; c <= 66; c++) push_snap(0, s + c, c <= 65, 1'b0, 1'b0, 1'b0);
        drain(200);

        // Five stall cycles on beat 7.
        launch(0, s);
        stall_lo[0] = s + 16;
        stall_hi[0] = s + 21;
        plan(0, s, 32, 7, 5, 1'b1, 1'b0);
        drain(200);

        // Abort while beat 10 is held, then a fresh dump.
        launch(0, s);
        stall_lo[0] = s + 22;
        stall_hi[0] = s + 30;
        plan(0, s, 10, 32, 0, 1'b0, 1'b0);
        wait_cyc(s + 22);
        push_snap(0, s + 23, 1'b0, 1'b1, 1'b0, 1'b0);
        abort[0] = 1'b1;
        @(negedge clock);
        abort[0] = 1'b0;
        wait_cyc(s + 32);
        drain(50);
        launch(0, s);
        plan(0, s, 32, 32, 0, 1'b1, 1'b0);
        drain(200);

        // Start while busy (SEND and DONE), plus writeback of x5 after its fetch.
        launch(0, s);
        plan(0, s, 32, 32, 0, 1'b1, 1'b0);
        push_snap(0, s + 66, 1'b0, 1'b1, 1'b0, 1'b0);
        push_snap(0, s + 67, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cyc(s + 12);
        rf[5] = 32'hDEADBEEF;
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        wait_cyc(s + 65);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        drain(200);
        launch(0, s);
        plan(0, s, 32, 32, 0, 1'b1, 1'b1);
        drain(200);
        rf[5] = 32'hA500_0005;

        // Reset pulse while beat 20 is held.
        launch(0, s);
        stall_lo[0] = s + 42;
        stall_hi[0] = s + 50;
        plan(0, s, 20, 32, 0, 1'b0, 1'b0);
        wait_cyc(s + 42);
        push_snap(0, s + 43, 1'b0, 1'b1, 1'b0, 1'b1);
        rst_n[0] = 1'b0;
        @(negedge clock);
        rst_n[0] = 1'b1;
        wait_cyc(s + 52);
        drain(50);

        // SKIP_ZERO instance: 31 beats, done in cycle 63.
        launch(1, s);
        plan(1, s, 31, 32, 0, 1'b1, 1'b0);
        push_snap(1, s + 64, 1'b0, 1'b1, 1'b0, 1'b0);
        drain(200);

        final_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
